// File: rtl/rename_map_if.sv
// rename_map_if: rename, rename-output and commit channels of the register rename map.
interface rename_map_if #(
    parameter int LA = 5,
    parameter int PA = 7
);
    logic          in_valid;
    logic          in_ready;
    logic [LA-1:0] in_rs1;
    logic [LA-1:0] in_rs2;
    logic [LA-1:0] in_rd;
    logic          in_rs1_valid;
    logic          in_rs2_valid;
    logic          in_rd_valid;
    logic          out_valid;
    logic          out_ready;
    logic [PA-1:0] out_prs1;
    logic [PA-1:0] out_prs2;
    logic [PA-1:0] out_prd;
    logic [PA-1:0] out_prd_old;
    logic          out_prd_valid;
    logic          commit_valid;
    logic          commit_rd_valid;
    logic [LA-1:0] commit_rd;
    logic [PA-1:0] commit_prd;
    logic [PA-1:0] commit_prd_old;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rs1_valid, in_rs2_valid, in_rd_valid,
        output in_ready,
        output out_valid, out_prs1, out_prs2, out_prd, out_prd_old, out_prd_valid,
        input  out_ready,
        input  commit_valid, commit_rd_valid, commit_rd, commit_prd, commit_prd_old
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rs1_valid, in_rs2_valid, in_rd_valid,
        input  in_ready,
        input  out_valid, out_prs1, out_prs2, out_prd, out_prd_old, out_prd_valid,
        output out_ready,
        output commit_valid, commit_rd_valid, commit_rd, commit_prd, commit_prd_old
    );
endinterface

// File: rtl/rename_map.sv
// rename_map: speculative/committed register map with a circular free list of physical registers.
module rename_map #(
    parameter int LOG_RF_DEPTH = 32,
    parameter int PHY_RF_DEPTH = 128,
    localparam int LA = $clog2(LOG_RF_DEPTH),
    localparam int PA = $clog2(PHY_RF_DEPTH),
    localparam int FL_DEPTH = PHY_RF_DEPTH - LOG_RF_DEPTH,
    localparam int FA = $clog2(FL_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    rename_map_if.slave   bus,
    input  logic          flush,
    output logic          busy_table_wr_en,
    output logic [PA-1:0] busy_table_wr_addr,
    output logic          busy_table_data_out,
    output logic [PA:0]   free_count
);
    localparam logic [PA:0] FULL = (PA+1)'(FL_DEPTH);

    logic [PA-1:0] map  [LOG_RF_DEPTH];
    logic [PA-1:0] cmap [LOG_RF_DEPTH];
    logic [PA-1:0] fl   [FL_DEPTH];
    logic [FA-1:0] head, tail, chead;
    logic [PA:0]   count;
    logic          accept, alloc, push_req, push;

    function automatic logic [FA-1:0] inc(input logic [FA-1:0] p);
        return p == FA'(FL_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign bus.in_ready = rst && (!bus.out_valid || bus.out_ready) && count != '0 && !flush;
    assign accept = bus.in_valid && bus.in_ready;
    assign alloc = accept && bus.in_rd_valid && bus.in_rd != '0;
    assign push_req = bus.commit_valid && bus.commit_rd_valid && bus.commit_rd != '0;
    assign push = push_req && count != FULL;

    assign busy_table_wr_en = alloc;
    assign busy_table_wr_addr = fl[head];
    assign busy_table_data_out = 1'b1;
    assign free_count = count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LOG_RF_DEPTH; i++) begin
                map[i] <= PA'(i);
                cmap[i] <= PA'(i);
            end
            for (int k = 0; k < FL_DEPTH; k++) fl[k] <= PA'(LOG_RF_DEPTH + k);
            head <= '0;
            tail <= '0;
            chead <= '0;
            count <= FULL;
            bus.out_valid <= 1'b0;
            bus.out_prs1 <= '0;
            bus.out_prs2 <= '0;
            bus.out_prd <= '0;
            bus.out_prd_old <= '0;
            bus.out_prd_valid <= 1'b0;
        end else begin
            if (push) begin
                fl[tail] <= bus.commit_prd_old;
                tail <= inc(tail);
                chead <= inc(chead);
                cmap[bus.commit_rd] <= bus.commit_prd;
            end
            // Flush restores the committed view, including this cycle's commit.
            if (flush) begin
                for (int i = 0; i < LOG_RF_DEPTH; i++)
                    map[i] <= (push && bus.commit_rd == LA'(i)) ? bus.commit_prd : cmap[i];
                head <= push ? inc(chead) : chead;
                count <= FULL;
                bus.out_valid <= 1'b0;
            end else begin
                if (alloc) begin
                    map[bus.in_rd] <= fl[head];
                    head <= inc(head);
                end
                count <= count + {{PA{1'b0}}, push} - {{PA{1'b0}}, alloc};
                if (accept) begin
                    bus.out_valid <= 1'b1;
                    bus.out_prs1 <= bus.in_rs1_valid ? map[bus.in_rs1] : '0;
                    bus.out_prs2 <= bus.in_rs2_valid ? map[bus.in_rs2] : '0;
                    bus.out_prd <= alloc ? fl[head] : '0;
                    bus.out_prd_old <= alloc ? map[bus.in_rd] : '0;
                    bus.out_prd_valid <= alloc;
                end else if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) assert (!push_req || count != FULL);
    end
endmodule
